// File: rtl/cache_refill_unit.sv
// Cache miss refill engine: latches the victim, optionally writes it back, then streams a line read into the data RAM.
// Build option: define CACHE_WRITEBACK_EN to enable dirty-victim writeback (WB_REQ state).
module cache_refill_unit #(
  parameter int IDX_W = 8,
  parameter int WAY_W = 1,
  parameter int OFF_W = 2,
  parameter int TAG_W = 20,
  parameter int WORDS = 1 << OFF_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  miss_req,
  input  logic [IDX_W-1:0]      miss_index,
  input  logic [WAY_W-1:0]      miss_way,
  input  logic [TAG_W-1:0]      miss_tag,
  input  logic [TAG_W-1:0]      victim_tag,
  input  logic                  victim_dirty,
  input  logic [WORDS*32-1:0]   victim_line,
  output logic                  miss_busy,
  output logic                  miss_done,
  output logic                  rd_req,
  output logic [31:0]           rd_addr,
  input  logic                  rd_rdy,
  input  logic                  ret_valid,
  input  logic                  ret_last,
  input  logic [31:0]           ret_data,
  output logic                  wr_req,
  output logic [31:0]           wr_addr,
  output logic [WORDS*32-1:0]   wr_data,
  input  logic                  wr_rdy,
  output logic                  ram_we,
  output logic [IDX_W-1:0]      ram_index,
  output logic [WAY_W-1:0]      ram_way,
  output logic [OFF_W-1:0]      ram_offset,
  output logic [31:0]           ram_din
);

`ifdef CACHE_WRITEBACK_EN
  typedef enum logic [2:0] {IDLE, WB_REQ, RD_REQ, REFILL, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RD_REQ, REFILL, DONE} state_t;
`endif

  state_t             state, state_nxt;
  logic [OFF_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx_q;
  logic [WAY_W-1:0]   way_q;
  logic [TAG_W-1:0]   tag_q;
`ifdef CACHE_WRITEBACK_EN
  logic [TAG_W-1:0]   vtag_q;
  logic [WORDS*32-1:0] line_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      idx_q  <= '0;
      way_q  <= '0;
      tag_q  <= '0;
`ifdef CACHE_WRITEBACK_EN
      vtag_q <= '0;
      line_q <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && miss_req) begin
        idx_q  <= miss_index;
        way_q  <= miss_way;
        tag_q  <= miss_tag;
`ifdef CACHE_WRITEBACK_EN
        vtag_q <= victim_tag;
        line_q <= victim_line;
`endif
      end
      if (state == RD_REQ && rd_rdy)
        cnt <= '0;
      else if (state == REFILL && ret_valid)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    miss_done = 1'b0;
    case (state)
      IDLE: begin
        if (miss_req) begin
`ifdef CACHE_WRITEBACK_EN
          state_nxt = victim_dirty ? WB_REQ : RD_REQ;
`else
          state_nxt = RD_REQ;
`endif
        end
      end
`ifdef CACHE_WRITEBACK_EN
      WB_REQ: begin
        wr_req = 1'b1;
        if (wr_rdy) state_nxt = RD_REQ;
      end
`endif
      RD_REQ: begin
        rd_req = 1'b1;
        if (rd_rdy) state_nxt = REFILL;
      end
      REFILL: begin
        if (ret_valid && ret_last) state_nxt = DONE;
      end
      DONE: begin
        miss_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gating with reset keeps a beat arriving in the reset cycle out of the RAM.
  assign ram_we     = (state == REFILL) && ret_valid && !reset;
  assign ram_din    = ret_data;
  assign ram_offset = cnt;
  assign ram_index  = idx_q;
  assign ram_way    = way_q;
  assign miss_busy  = (state != IDLE);
  assign rd_addr    = {tag_q, idx_q, {OFF_W{1'b0}}, 2'b00};

`ifdef CACHE_WRITEBACK_EN
  assign wr_addr = {vtag_q, idx_q, {OFF_W{1'b0}}, 2'b00};
  assign wr_data = line_q;
`else
  logic unused_wb;
  assign unused_wb = ^{victim_tag, victim_dirty, victim_line, wr_rdy};
  assign wr_addr   = '0;
  assign wr_data   = '0;
`endif

endmodule

// File: tb/tb_cache_refill_unit.sv
// Directed bench for cache_refill_unit: clean, gapped, reset-abort and (build dependent) writeback misses.
module tb_cache_refill_unit;
  localparam int IDX_W = 8, WAY_W = 1, OFF_W = 2, TAG_W = 20, WORDS = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                miss_req = 1'b0;
  logic [IDX_W-1:0]    miss_index = '0;
  logic [WAY_W-1:0]    miss_way = '0;
  logic [TAG_W-1:0]    miss_tag = '0;
  logic [TAG_W-1:0]    victim_tag = '0;
  logic                victim_dirty = 1'b0;
  logic [WORDS*32-1:0] victim_line = '0;
  logic                miss_busy, miss_done, rd_req, wr_req, ram_we;
  logic [31:0]         rd_addr, wr_addr, ram_din;
  logic [WORDS*32-1:0] wr_data;
  logic                rd_rdy = 1'b0, ret_valid = 1'b0, ret_last = 1'b0, wr_rdy = 1'b0;
  logic [31:0]         ret_data = '0;
  logic [IDX_W-1:0]    ram_index;
  logic [WAY_W-1:0]    ram_way;
  logic [OFF_W-1:0]    ram_offset;

  int n_checks = 0;
  int n_fail = 0;

  cache_refill_unit #(.IDX_W(IDX_W), .WAY_W(WAY_W), .OFF_W(OFF_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .miss_req(miss_req), .miss_index(miss_index), .miss_way(miss_way),
    .miss_tag(miss_tag), .victim_tag(victim_tag), .victim_dirty(victim_dirty), .victim_line(victim_line),
    .miss_busy(miss_busy), .miss_done(miss_done), .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_rdy(wr_rdy), .ram_we(ram_we), .ram_index(ram_index), .ram_way(ram_way),
    .ram_offset(ram_offset), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Inputs change on the falling edge; checks run 1 time unit later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic start_miss(input logic [7:0] idx, input logic way, input logic [19:0] tag,
                            input logic [19:0] vtag, input logic dirty);
    miss_req = 1'b1; miss_index = idx; miss_way = way; miss_tag = tag;
    victim_tag = vtag; victim_dirty = dirty;
  endtask

  int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
  int exp_off;

  initial begin
    // reset
    cyc(); cyc();
    #1;
    chk("rst_busy", miss_busy, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_done", miss_done, 0);
    chk("rst_index", ram_index, 0);
    chk("rst_offset", ram_offset, 0);
    cyc(); reset = 1'b0;

    // 1: clean miss, rd_rdy high, 4 back-to-back beats
    cyc(); start_miss(8'h12, 1'b1, 20'hABCDE, 20'h0, 1'b0); rd_rdy = 1'b1;
    #1 chk("t1_idle_busy", miss_busy, 0);
    cyc(); miss_req = 1'b0;
    #1 chk("t1_rd_req", rd_req, 1);
    chk("t1_rd_addr", rd_addr, 32'hABCDE120);
    chk("t1_busy", miss_busy, 1);
    chk("t1_index", ram_index, 8'h12);
    chk("t1_way", ram_way, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(); ret_valid = 1'b1; ret_data = 32'h11 * (i + 1); ret_last = (i == 3);
      #1 chk("t1_we", ram_we, 1);
      chk("t1_off", ram_offset, i);
      chk("t1_din", ram_din, 32'h11 * (i + 1));
      chk("t1_rd_req_low", rd_req, 0);
    end
    cyc(); ret_valid = 1'b0; ret_last = 1'b0;
    #1 chk("t1_done", miss_done, 1);
    chk("t1_done_we", ram_we, 0);
    cyc();
    #1 chk("t1_done_pulse", miss_done, 0);
    chk("t1_idle", miss_busy, 0);

    // 3+4: gapped return, stray ret_valid in RD_REQ, miss_req pulse during REFILL
    start_miss(8'h12, 1'b0, 20'h12345, 20'h0, 1'b0); rd_rdy = 1'b0;
    cyc(); miss_req = 1'b0; ret_valid = 1'b1;
    #1 chk("t3_rd_req", rd_req, 1);
    chk("t3_stray_we", ram_we, 0);
    cyc(); rd_rdy = 1'b1; ret_valid = 1'b0;
    #1 chk("t3_rd_req2", rd_req, 1);
    exp_off = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(); ret_valid = (pat[i] == 1); ret_last = (i == 6); ret_data = 32'hA0 + i;
      miss_req = (i == 1); miss_index = (i == 1) ? 8'h55 : 8'h12;
      #1 chk("t3_we", ram_we, pat[i]);
      chk("t4_index", ram_index, 8'h12);
      if (pat[i] == 1) begin
        chk("t3_off", ram_offset, exp_off);
        exp_off++;
      end
    end
    cyc(); ret_valid = 1'b0; ret_last = 1'b0; miss_req = 1'b0;
    #1 chk("t3_writes", exp_off, 4);
    chk("t3_done", miss_done, 1);
    cyc();
    #1 chk("t4_not_restarted", miss_busy, 0);

    // 5: reset after 2nd beat, then restart with an early ret_last
    start_miss(8'h33, 1'b1, 20'h0F0F0, 20'h0, 1'b0);
    cyc(); miss_req = 1'b0;
    cyc(); ret_valid = 1'b1;
    cyc();
    cyc(); reset = 1'b1;
    #1 chk("t5_reset_we", ram_we, 0);
    cyc(); reset = 1'b0;
    #1 chk("t5_busy", miss_busy, 0);
    chk("t5_we_idle", ram_we, 0);
    chk("t5_rd_req", rd_req, 0);
    ret_valid = 1'b0;
    start_miss(8'h34, 1'b0, 20'h0F0F1, 20'h0, 1'b0);
    cyc(); miss_req = 1'b0;
    #1 chk("t5_rd_addr", rd_addr, 32'h0F0F1340);
    cyc(); ret_valid = 1'b1; ret_data = 32'hBEEF0000;
    #1 chk("t5_off0", ram_offset, 0);
    chk("t5_we", ram_we, 1);
    cyc(); ret_last = 1'b1; ret_data = 32'hBEEF0001;
    #1 chk("t5_off1", ram_offset, 1);
    cyc(); ret_valid = 1'b0; ret_last = 1'b0;
    #1 chk("t5_early_done", miss_done, 1);
    cyc();

`ifdef CACHE_WRITEBACK_EN
    // 2: dirty miss, wr_rdy low for 3 cycles
    victim_line = 128'h44444444_33333333_22222222_11111111;
    start_miss(8'h48, 1'b0, 20'h22222, 20'h00001, 1'b1); wr_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(); miss_req = 1'b0; wr_rdy = (k == 3);
      #1 chk("t2_wr_req", wr_req, 1);
      chk("t2_rd_req_low", rd_req, 0);
      chk("t2_wr_addr", wr_addr, 32'h00001480);
      chk("t2_wr_data", wr_data, 128'h44444444_33333333_22222222_11111111);
    end
    cyc(); wr_rdy = 1'b0;
    #1 chk("t2_wr_dropped", wr_req, 0);
    chk("t2_rd_req", rd_req, 1);
    chk("t2_rd_addr", rd_addr, 32'h22222480);
    cyc(); ret_valid = 1'b1; ret_last = 1'b1;
    #1 chk("t2_we", ram_we, 1);
    cyc(); ret_valid = 1'b0; ret_last = 1'b0;
    #1 chk("t2_done", miss_done, 1);
    cyc();
`else
    // 6: write-through build ignores victim_dirty
    victim_line = 128'h44444444_33333333_22222222_11111111;
    start_miss(8'h48, 1'b0, 20'h22222, 20'h00001, 1'b1); wr_rdy = 1'b1;
    cyc(); miss_req = 1'b0;
    #1 chk("t6_rd_req", rd_req, 1);
    chk("t6_wr_req", wr_req, 0);
    chk("t6_wr_addr", wr_addr, 0);
    chk("t6_wr_data", wr_data, 0);
    cyc(); ret_valid = 1'b1; ret_last = 1'b1;
    #1 chk("t6_wr_req_refill", wr_req, 0);
    cyc(); ret_valid = 1'b0; ret_last = 1'b0;
    #1 chk("t6_done", miss_done, 1);
    cyc();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
